// File: rtl/prefetch_unit_pkg.sv
// Shared core definitions for the fetch path: default widths, PC stride and
// the fetch-entry layout handed from the prefetch queue to the decoder.
package prefetch_unit_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int ILEN         = 32;
    localparam int PC_STEP      = 4;
    localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Queue entry as seen by decode: PC in the upper half, instruction below.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [ILEN-1:0]         instr;
    } fetch_entry_t;

    // Width of an occupancy counter that must be able to hold the value depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prefetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count. The head word is
// read combinationally so a word written at one edge is visible right after
// that edge, which the fetch path relies on for its two-cycle latency.
module prefetch_unit_sync_fifo
    import prefetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // Flush dominates: nothing is written or consumed in a flush cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem_reg[rd_ptr_reg];

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues pipelined fetch requests toward
// instruction memory under a credit limit, queues returning words with their
// PCs for decode, and on a redirect flushes the queue and squashes every
// response still in flight for the old path.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready
);

    localparam int CW = cnt_width(DEPTH);

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_reg, discard_next;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] fifo_rd_data;
    logic [2*XLEN-1:0] fifo_wr_data;

    logic [CW:0]     credit_used;
    logic            issue;
    logic            drop_rsp;
    logic            push_en;
    logic            pop_en;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_lsbs;

    // Low target bits are forced to zero, so they never influence anything.
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
    assign redirect_target      = {i_redirect_pc[XLEN-1:2], 2'b00};

    // Queued words plus words still owed by memory never exceed DEPTH, which
    // is what guarantees every accepted response has a free queue slot.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign o_imem_req  = !reset && !i_redirect && (credit_used < (CW+1)'(DEPTH));
    assign o_imem_addr = fetch_pc_reg;
    assign issue       = o_imem_req && i_imem_gnt;

    // Responses belonging to a squashed path are dropped while discard is nonzero.
    assign drop_rsp = i_imem_rvalid && (discard_reg != '0);
    assign push_en  = i_imem_rvalid && !drop_rsp && !i_redirect;
    assign pop_en   = o_valid && i_ready && !i_redirect;

    assign fifo_wr_data = {rsp_pc_reg, i_imem_rdata};
    assign o_valid      = !fifo_empty;
    assign o_pc         = fifo_rd_data[2*XLEN-1:XLEN];
    assign o_instr      = fifo_rd_data[XLEN-1:0];

    prefetch_unit_sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .srst      (reset),
        .flush     (i_redirect),
        .push      (push_en),
        .push_data (fifo_wr_data),
        .pop       (pop_en),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state for PCs and the in-flight/discard counters; redirect wins.
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        discard_next     = discard_reg;
        outstanding_next = outstanding_reg + CW'(issue) - CW'(i_imem_rvalid);

        if (i_redirect) begin
            // Everything still owed by memory, minus the word arriving now,
            // belongs to the old path and must be thrown away.
            fetch_pc_next = redirect_target;
            rsp_pc_next   = redirect_target;
            discard_next  = outstanding_reg - CW'(i_imem_rvalid);
        end else begin
            if (issue) begin
                fetch_pc_next = fetch_pc_reg + XLEN'(PC_STEP);
            end
            if (push_en) begin
                rsp_pc_next = rsp_pc_reg + XLEN'(PC_STEP);
            end
            if (drop_rsp) begin
                discard_next = discard_reg - CW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    // Protocol and counter sanity checks.
    assert property (@(posedge clk) disable iff (reset)
        !(i_imem_rvalid && (outstanding_reg == '0)))
        else $error("imem response with nothing outstanding");

    assert property (@(posedge clk) disable iff (reset)
        !(push_en && fifo_full && !pop_en))
        else $error("push into full prefetch queue");

    assert property (@(posedge clk) disable iff (reset)
        (outstanding_reg <= CW'(DEPTH)) && (discard_reg <= outstanding_reg))
        else $error("outstanding/discard counter out of range");

    assert property (@(posedge clk) disable iff (reset)
        !(issue && (outstanding_reg == CW'(DEPTH))))
        else $error("outstanding counter overflow");

endmodule
